// File: rtl/flexbex_ibex_rf_writeback_pkg.sv
// Shared definitions for the register-file writeback slice.
// - ADDR_WIDTH_*/NUM_WORDS_*: register-file geometry for RV32I and RV32E
// - reg_addr_t: 5-bit register address, shared with the register file
// - addr_eq/addr_nz: address compare helpers honouring the RV32E address fold
package flexbex_ibex_rf_writeback_pkg;

  localparam int ADDR_WIDTH_I = 5;
  localparam int ADDR_WIDTH_E = 4;
  localparam int NUM_WORDS_I  = 32;
  localparam int NUM_WORDS_E  = 16;

  typedef logic [4:0] reg_addr_t;

  // RV32E has 16 registers, so bit 4 of an address carries no meaning.
  function automatic logic addr_eq(reg_addr_t x, reg_addr_t y, logic rv32e);
    return rv32e ? (x[3:0] == y[3:0]) : (x == y);
  endfunction

  // Non-zero test; under RV32E address 16 aliases x0.
  function automatic logic addr_nz(reg_addr_t x, logic rv32e);
    return rv32e ? (x[3:0] != 4'd0) : (x != 5'd0);
  endfunction

endpackage

// File: rtl/flexbex_ibex_rf_writeback_if.sv
// Bundle of the EX, LSU, decode-read and register-file-write signals around
// the writeback unit. The slave modport is the writeback unit; the master
// modport is the surrounding core (EX/LSU/decode/register file).
interface flexbex_ibex_rf_writeback_if
  import flexbex_ibex_rf_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid_i;
  reg_addr_t             ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  logic                  ex_ready_o;
  logic                  ld_issue_i;
  reg_addr_t             ld_issue_waddr_i;
  logic                  ld_issue_ready_o;
  logic                  lsu_rvalid_i;
  logic [DATA_WIDTH-1:0] lsu_rdata_i;
  reg_addr_t             raddr_a_i;
  reg_addr_t             raddr_b_i;
  logic [DATA_WIDTH-1:0] rf_rdata_a_i;
  logic [DATA_WIDTH-1:0] rf_rdata_b_i;
  logic [DATA_WIDTH-1:0] rdata_a_o;
  logic [DATA_WIDTH-1:0] rdata_b_o;
  logic                  busy_a_o;
  logic                  busy_b_o;
  reg_addr_t             waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic                  we_a_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i, ld_issue_i, ld_issue_waddr_i,
           lsu_rvalid_i, lsu_rdata_i, raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    output ex_ready_o, ld_issue_ready_o, rdata_a_o, rdata_b_o, busy_a_o, busy_b_o,
           waddr_a_o, wdata_a_o, we_a_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i, ld_issue_i, ld_issue_waddr_i,
           lsu_rvalid_i, lsu_rdata_i, raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
    input  ex_ready_o, ld_issue_ready_o, rdata_a_o, rdata_b_o, busy_a_o, busy_b_o,
           waddr_a_o, wdata_a_o, we_a_o
  );
endinterface

// File: rtl/flexbex_ibex_rf_load_fifo.sv
// In-order FIFO of outstanding load destination addresses.
// Ports: clk/rst_n; push/push_addr (caller guarantees !full);
// pop (ignored when empty); cmp_ex/cmp_a/cmp_b compare addresses;
// head_addr (oldest entry), full, empty, match[0]=ex, [1]=a, [2]=b.
module flexbex_ibex_rf_load_fifo
  import flexbex_ibex_rf_writeback_pkg::*;
#(
  parameter int MAX_LOADS = 2,
  parameter bit RV32E     = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  reg_addr_t push_addr,
  input  logic      pop,
  input  reg_addr_t cmp_ex,
  input  reg_addr_t cmp_a,
  input  reg_addr_t cmp_b,
  output reg_addr_t head_addr,
  output logic      full,
  output logic      empty,
  output logic [2:0] match
);
  localparam int PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int CNT_W = $clog2(MAX_LOADS) + 1;

  reg_addr_t             addr_q [MAX_LOADS];
  logic [MAX_LOADS-1:0]  valid_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count == CNT_W'(MAX_LOADS));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = addr_q[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LOADS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entries being popped this cycle are still valid here, so a WAW stall
  // holds through the return cycle.
  always_comb begin
    match = '0;
    for (int i = 0; i < MAX_LOADS; i++) begin
      if (valid_q[i]) begin
        match[0] = match[0] | addr_eq(addr_q[i], cmp_ex, RV32E);
        match[1] = match[1] | addr_eq(addr_q[i], cmp_a, RV32E);
        match[2] = match[2] | addr_eq(addr_q[i], cmp_b, RV32E);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (pop_ok) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Address storage carries no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (push_ok) addr_q[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/flexbex_ibex_rf_writeback.sv
// Single write-port arbiter and hazard unit for the flop-based register file.
// Merges EX results and in-order load returns onto one registered write port,
// tracks outstanding load destinations for decode RAW/WAW stalls, and forwards
// the in-flight write onto the two read ports.
// Ports: clk, rst_n (async active-low); bus (slave side of
// flexbex_ibex_rf_writeback_if) carrying EX/LSU/decode/register-file signals.
module flexbex_ibex_rf_writeback
  import flexbex_ibex_rf_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit RV32E      = 1'b0,
  parameter int MAX_LOADS  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  flexbex_ibex_rf_writeback_if.slave   bus
);
  reg_addr_t             head_addr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2:0]            match;
  logic                  pop;
  logic                  push;
  logic                  ex_ready;
  logic                  ex_fire;

  logic                  we_p1;
  reg_addr_t             waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  assign pop      = bus.lsu_rvalid_i && !fifo_empty;
  assign push     = bus.ld_issue_i && !fifo_full;
  // Load returns have absolute priority; a pending load to the same
  // destination blocks EX to keep write order.
  assign ex_ready = !bus.lsu_rvalid_i && !match[0];
  assign ex_fire  = bus.ex_valid_i && ex_ready;

  flexbex_ibex_rf_load_fifo #(
    .MAX_LOADS (MAX_LOADS),
    .RV32E     (RV32E)
  ) u_load_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (bus.ld_issue_waddr_i),
    .pop       (pop),
    .cmp_ex    (bus.ex_waddr_i),
    .cmp_a     (bus.raddr_a_i),
    .cmp_b     (bus.raddr_b_i),
    .head_addr (head_addr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .match     (match)
  );

  // Stage p1: registered register-file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (pop) begin
      we_p1    <= addr_nz(head_addr, RV32E);
      waddr_p1 <= head_addr;
      wdata_p1 <= bus.lsu_rdata_i;
    end else if (ex_fire) begin
      we_p1    <= addr_nz(bus.ex_waddr_i, RV32E);
      waddr_p1 <= bus.ex_waddr_i;
      wdata_p1 <= bus.ex_wdata_i;
    end else begin
      we_p1    <= 1'b0;
    end
  end

  assign bus.we_a_o           = we_p1;
  assign bus.waddr_a_o        = waddr_p1;
  assign bus.wdata_a_o        = wdata_p1;
  assign bus.ex_ready_o       = ex_ready;
  assign bus.ld_issue_ready_o = !fifo_full;

  assign bus.busy_a_o = addr_nz(bus.raddr_a_i, RV32E) && match[1];
  assign bus.busy_b_o = addr_nz(bus.raddr_b_i, RV32E) && match[2];

  // The register file commits at the end of the we_p1 cycle, so the value
  // it returns this cycle is stale; bypass it.
  assign bus.rdata_a_o = (we_p1 && addr_nz(bus.raddr_a_i, RV32E) &&
                          addr_eq(waddr_p1, bus.raddr_a_i, RV32E)) ? wdata_p1 : bus.rf_rdata_a_i;
  assign bus.rdata_b_o = (we_p1 && addr_nz(bus.raddr_b_i, RV32E) &&
                          addr_eq(waddr_p1, bus.raddr_b_i, RV32E)) ? wdata_p1 : bus.rf_rdata_b_i;

endmodule

// File: tb/tb_flexbex_ibex_rf_writeback.sv
// Directed bench for flexbex_ibex_rf_writeback (DATA_WIDTH=32, RV32I, MAX_LOADS=2).
module tb_flexbex_ibex_rf_writeback;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  flexbex_ibex_rf_writeback_if #(.DATA_WIDTH(32)) bus ();

  flexbex_ibex_rf_writeback #(
    .DATA_WIDTH (32),
    .RV32E      (1'b0),
    .MAX_LOADS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ex_valid_i       = 1'b0;
    bus.ex_waddr_i       = '0;
    bus.ex_wdata_i       = '0;
    bus.ld_issue_i       = 1'b0;
    bus.ld_issue_waddr_i = '0;
    bus.lsu_rvalid_i     = 1'b0;
    bus.lsu_rdata_i      = '0;
    bus.raddr_a_i        = '0;
    bus.raddr_b_i        = '0;
    bus.rf_rdata_a_i     = '0;
    bus.rf_rdata_b_i     = '0;
    #12;
    chk("rst_we", bus.we_a_o, 0);
    chk("rst_waddr", bus.waddr_a_o, 0);
    chk("rst_wdata", bus.wdata_a_o, 0);
    chk("rst_ld_ready", bus.ld_issue_ready_o, 1);
    chk("rst_ex_ready", bus.ex_ready_o, 1);
    rst_n = 1'b1;
    tick();

    // EX write x5 and forwarding onto port a
    bus.ex_valid_i = 1; bus.ex_waddr_i = 5; bus.ex_wdata_i = 32'hDEADBEEF;
    #1 chk("ex_ready_idle", bus.ex_ready_o, 1);
    tick();
    bus.ex_valid_i = 0;
    bus.raddr_a_i = 5; bus.rf_rdata_a_i = 32'h11111111;
    bus.raddr_b_i = 6; bus.rf_rdata_b_i = 32'h22222222;
    #1;
    chk("ex_we", bus.we_a_o, 1);
    chk("ex_waddr", bus.waddr_a_o, 5);
    chk("ex_wdata", bus.wdata_a_o, 32'hDEADBEEF);
    chk("fwd_a", bus.rdata_a_o, 32'hDEADBEEF);
    chk("nofwd_b", bus.rdata_b_o, 32'h22222222);
    tick();
    chk("idle_we", bus.we_a_o, 0);
    chk("idle_waddr_held", bus.waddr_a_o, 5);
    chk("idle_wdata_held", bus.wdata_a_o, 32'hDEADBEEF);
    chk("idle_nofwd_a", bus.rdata_a_o, 32'h11111111);

    // Load to x7 with busy and forward on port b
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 7; bus.raddr_b_i = 7;
    #1 chk("busy_b_before_push", bus.busy_b_o, 0);
    tick();
    bus.ld_issue_i = 0;
    #1;
    chk("busy_b_pending", bus.busy_b_o, 1);
    chk("ld_ready_one", bus.ld_issue_ready_o, 1);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h1234;
    #1;
    chk("busy_b_return_cycle", bus.busy_b_o, 1);
    chk("ex_ready_during_return", bus.ex_ready_o, 0);
    tick();
    bus.lsu_rvalid_i = 0;
    #1;
    chk("ld7_we", bus.we_a_o, 1);
    chk("ld7_waddr", bus.waddr_a_o, 7);
    chk("ld7_wdata", bus.wdata_a_o, 32'h1234);
    chk("ld7_fwd_b", bus.rdata_b_o, 32'h1234);
    chk("ld7_busy_b", bus.busy_b_o, 0);

    // Load return and EX in the same cycle
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 9;
    tick();
    bus.ld_issue_i = 0;
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'hAAAA;
    bus.ex_valid_i = 1; bus.ex_waddr_i = 10; bus.ex_wdata_i = 32'hBBBB;
    #1 chk("coll_ex_ready", bus.ex_ready_o, 0);
    tick();
    bus.lsu_rvalid_i = 0;
    #1;
    chk("coll_ld_waddr", bus.waddr_a_o, 9);
    chk("coll_ld_wdata", bus.wdata_a_o, 32'hAAAA);
    chk("coll_ex_ready_after", bus.ex_ready_o, 1);
    tick();
    bus.ex_valid_i = 0;
    chk("coll_ex_we", bus.we_a_o, 1);
    chk("coll_ex_waddr", bus.waddr_a_o, 10);
    chk("coll_ex_wdata", bus.wdata_a_o, 32'hBBBB);

    // Fill both slots, then in-order returns
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 1;
    tick();
    bus.ld_issue_waddr_i = 2;
    tick();
    bus.ld_issue_i = 0;
    chk("full_ld_ready", bus.ld_issue_ready_o, 0);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h1;
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 4;
    #1 chk("full_pop_no_early_free", bus.ld_issue_ready_o, 0);
    tick();
    bus.ld_issue_i = 0;
    bus.lsu_rvalid_i = 0;
    bus.raddr_a_i = 4; bus.raddr_b_i = 2;
    #1;
    chk("ret1_we", bus.we_a_o, 1);
    chk("ret1_waddr", bus.waddr_a_o, 1);
    chk("ret1_wdata", bus.wdata_a_o, 32'h1);
    chk("ret1_ld_ready", bus.ld_issue_ready_o, 1);
    chk("dropped_issue_busy_a", bus.busy_a_o, 0);
    chk("x2_busy_b", bus.busy_b_o, 1);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h2;
    tick();
    bus.lsu_rvalid_i = 0;
    #1;
    chk("ret2_waddr", bus.waddr_a_o, 2);
    chk("ret2_wdata", bus.wdata_a_o, 32'h2);
    chk("ret2_busy_b", bus.busy_b_o, 0);

    // WAW stall on x3
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 3;
    tick();
    bus.ld_issue_i = 0;
    bus.ex_valid_i = 1; bus.ex_waddr_i = 3; bus.ex_wdata_i = 32'h33;
    #1 chk("waw_ex_ready", bus.ex_ready_o, 0);
    tick();
    chk("waw_no_write", bus.we_a_o, 0);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h3;
    #1 chk("waw_ex_ready_pop", bus.ex_ready_o, 0);
    tick();
    bus.lsu_rvalid_i = 0;
    #1;
    chk("waw_ld_waddr", bus.waddr_a_o, 3);
    chk("waw_ld_wdata", bus.wdata_a_o, 32'h3);
    chk("waw_ex_ready_free", bus.ex_ready_o, 1);
    tick();
    bus.ex_valid_i = 0;
    chk("waw_ex_we", bus.we_a_o, 1);
    chk("waw_ex_wdata", bus.wdata_a_o, 32'h33);

    // x0 destinations
    bus.ex_valid_i = 1; bus.ex_waddr_i = 0; bus.ex_wdata_i = 32'h55;
    #1 chk("x0_ex_ready", bus.ex_ready_o, 1);
    tick();
    bus.ex_valid_i = 0;
    bus.raddr_a_i = 0; bus.rf_rdata_a_i = 32'h77;
    #1;
    chk("x0_ex_we", bus.we_a_o, 0);
    chk("x0_rdata_a", bus.rdata_a_o, 32'h77);
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 0;
    tick();
    bus.ld_issue_i = 0;
    #1;
    chk("x0_busy_a", bus.busy_a_o, 0);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'h99;
    tick();
    chk("x0_ld_we", bus.we_a_o, 0);
    tick();
    bus.lsu_rvalid_i = 0;
    chk("empty_rvalid_we", bus.we_a_o, 0);
    chk("empty_rvalid_ld_ready", bus.ld_issue_ready_o, 1);

    // Reset mid-operation drops pending load
    bus.ld_issue_i = 1; bus.ld_issue_waddr_i = 6;
    tick();
    bus.ld_issue_i = 0;
    bus.raddr_a_i = 6;
    #1 chk("pre_rst_busy_a", bus.busy_a_o, 1);
    rst_n = 0;
    #2 rst_n = 1;
    #1 chk("post_rst_busy_a", bus.busy_a_o, 0);
    bus.lsu_rvalid_i = 1; bus.lsu_rdata_i = 32'hEE;
    tick();
    bus.lsu_rvalid_i = 0;
    chk("post_rst_rvalid_we", bus.we_a_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
